// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the two-input gate bench checkers.
//   state_t     : checker FSM states (IDLE, RUN, DONE)
//   gate_expect : golden {and, xor} result for one operand pair
package gate_check_pkg;

  localparam int unsigned GATE_OUT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {a & b, a ^ b}.
  function automatic logic [GATE_OUT_W-1:0] gate_expect(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the AND/XOR gate pair.
//   a, b    : operands
//   exp_and : expected AND output
//   exp_xor : expected XOR output
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic exp_and,
  output logic exp_xor
);

  assign {exp_and, exp_xor} = gate_expect(a, b);

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for the AND/XOR gate bench: compares each sampled vector
// against the golden model, counts vectors and mismatches, captures the index
// of the first mismatch and gives a pass/fail verdict after NUM_VECTORS vectors.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin/restart a run (clears all results)
//   in_valid          : in_a/in_b/and_out/xor_out valid this cycle
//   busy / done       : FSM in RUN / DONE
//   pass              : verdict, valid while done
//   fail_pulse        : one cycle per mismatching vector
//   vec_count         : vectors accepted this run
//   err_count         : mismatching vectors (saturating)
//   first_fail_valid  : a mismatch has been captured
//   first_fail_idx    : 0-based index of the first mismatch
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             and_out,
  input  logic             xor_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [CNT_W-1:0] vec_n, err_n, ffi_n;
  logic             ffv_n, fail_n, pass_n;
  logic             exp_and_c, exp_xor_c, mismatch_c;

  gate_ref_model u_ref (
    .a       (in_a),
    .b       (in_b),
    .exp_and (exp_and_c),
    .exp_xor (exp_xor_c)
  );

  // Either output wrong makes one error for the vector.
  assign mismatch_c = (and_out != exp_and_c) || (xor_out != exp_xor_c);

  // Next-state and next-result logic.
  always_comb begin
    state_n = state;
    vec_n   = vec_count;
    err_n   = err_count;
    ffv_n   = first_fail_valid;
    ffi_n   = first_fail_idx;
    pass_n  = pass;
    fail_n  = 1'b0;

    case (state)
      IDLE, DONE: begin
        // Strobes are ignored here; start wins over a coincident vector.
        if (start) begin
          state_n = RUN;
          vec_n   = '0;
          err_n   = '0;
          ffv_n   = 1'b0;
          ffi_n   = '0;
          pass_n  = 1'b0;
        end
      end
      RUN: begin
        if (start) begin
          // Abort and restart; a vector on this cycle is dropped.
          vec_n  = '0;
          err_n  = '0;
          ffv_n  = 1'b0;
          ffi_n  = '0;
          pass_n = 1'b0;
        end else if (in_valid) begin
          vec_n = vec_count + CNT_W'(1);
          if (mismatch_c) begin
            fail_n = 1'b1;
            if (err_count != CNT_MAX) err_n = err_count + CNT_W'(1);
            if (!first_fail_valid) begin
              ffv_n = 1'b1;
              ffi_n = vec_count;
            end
          end
          if (vec_n == LAST_COUNT) begin
            state_n = DONE;
            pass_n  = (err_n == '0);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_pulse       <= 1'b0;
      vec_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      state            <= state_n;
      busy             <= (state_n == RUN);
      done             <= (state_n == DONE);
      pass             <= pass_n;
      fail_pulse       <= fail_n;
      vec_count        <= vec_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_idx   <= ffi_n;
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker (NUM_VECTORS=4, CNT_W=8).
module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_a = 1'b0;
  logic       in_b = 1'b0;
  logic       and_out = 1'b0;
  logic       xor_out = 1'b0;
  logic       busy, done, pass, fail_pulse, first_fail_valid;
  logic [7:0] vec_count, err_count, first_fail_idx;

  int n_checks = 0;
  int n_fail   = 0;

  gate_response_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .in_valid         (in_valid),
    .in_a             (in_a),
    .in_b             (in_b),
    .and_out          (and_out),
    .xor_out          (xor_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_pulse       (fail_pulse),
    .vec_count        (vec_count),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against the expected set.
  task automatic chk_all(input string tag, input logic e_busy, input logic e_done,
                         input logic e_pass, input logic e_fp, input logic [7:0] e_vec,
                         input logic [7:0] e_err, input logic e_ffv, input logic [7:0] e_ffi);
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".pass"}, 32'(pass), 32'(e_pass));
    chk({tag, ".fail_pulse"}, 32'(fail_pulse), 32'(e_fp));
    chk({tag, ".vec_count"}, 32'(vec_count), 32'(e_vec));
    chk({tag, ".err_count"}, 32'(err_count), 32'(e_err));
    chk({tag, ".ffv"}, 32'(first_fail_valid), 32'(e_ffv));
    chk({tag, ".ffi"}, 32'(first_fail_idx), 32'(e_ffi));
  endtask

  // One clock: drive at negedge, let the posedge sample, release, settle.
  task automatic step(input logic st, input logic v, input logic a, input logic b,
                      input logic ao, input logic xo);
    @(negedge clk);
    start = st; in_valid = v; in_a = a; in_b = b; and_out = ao; xor_out = xo;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; and_out = 1'b0; xor_out = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Strobe in IDLE is ignored
    step(0, 1, 1, 1, 0, 0);
    chk_all("idle_strobe", 0, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);

    // All pass; start together with a vector in IDLE drops the vector
    step(1, 1, 1, 1, 1, 0);
    chk_all("t1_start", 1, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("t1_v0.vec", 32'(vec_count), 32'd1);
    step(0, 1, 0, 1, 0, 1);
    chk("t1_v1.vec", 32'(vec_count), 32'd2);
    step(0, 1, 1, 1, 1, 0);
    chk("t1_v2.vec", 32'(vec_count), 32'd3);
    chk("t1_v2.busy", 32'(busy), 32'd1);
    step(0, 1, 1, 0, 0, 1);
    chk_all("t1_end", 0, 1, 1, 0, 8'd4, 8'd0, 0, 8'd0);

    // Single fault on third vector
    step(1, 0, 0, 0, 0, 0);
    chk_all("t2_start", 1, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    chk("t2_v1.fp", 32'(fail_pulse), 32'd0);
    step(0, 1, 1, 1, 0, 0);
    chk_all("t2_v2", 1, 0, 0, 1, 8'd3, 8'd1, 1, 8'd2);
    step(0, 1, 1, 0, 0, 1);
    chk_all("t2_end", 0, 1, 0, 0, 8'd4, 8'd1, 1, 8'd2);

    // Double-wrong vector 0, gaps, later fault on vector 3
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    chk_all("t3_v0", 1, 0, 0, 1, 8'd1, 8'd1, 1, 8'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("t3_v1.fp", 32'(fail_pulse), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0);
      chk("t3_gap.vec", 32'(vec_count), 32'd2);
      chk("t3_gap.err", 32'(err_count), 32'd1);
    end
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0, 0);
    chk_all("t3_end", 0, 1, 0, 1, 8'd4, 8'd2, 1, 8'd0);
    // Strobe in DONE is ignored
    step(0, 1, 1, 1, 0, 0);
    chk_all("done_strobe", 0, 1, 0, 0, 8'd4, 8'd2, 1, 8'd0);

    // Restart during RUN with a coincident (bad) vector
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk("t5_pre.vec", 32'(vec_count), 32'd2);
    step(1, 1, 1, 1, 0, 0);
    chk_all("t5_restart", 1, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 1, 1, 1, 0);
    chk("t5_v2.busy", 32'(busy), 32'd1);
    step(0, 1, 1, 0, 0, 1);
    chk_all("t5_end", 0, 1, 1, 0, 8'd4, 8'd0, 0, 8'd0);

    // Reset mid-run after one failing vector
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1);
    chk_all("t6_fail", 1, 0, 0, 1, 8'd1, 8'd1, 1, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t6_async_rst", 0, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0, 0, 0);
    chk_all("t6_after", 0, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

- Sequential checker at the response end of the two-input gate bench: the bench drives operand pairs into the AND/XOR gate pair, and this block samples each pair and the two gate outputs.
- Compares each sample against the expected `a & b` / `a ^ b`, counts vectors and mismatches, and records the index of the first failure.
- Issues a single pass/fail verdict after a programmed number of vectors.

## Interface
Parameters:
- `NUM_VECTORS`, 4: vectors accepted per run; legal range 1 to 2^CNT_W-1.
- `CNT_W`, 8: width of the vector and error counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run and clears all results.
- `in_valid`  in  1  sample strobe; a, b, and_out, xor_out are valid this cycle.
- `in_a`  in  1  operand a applied to the gates.
- `in_b`  in  1  operand b applied to the gates.
- `and_out`  in  1  observed AND gate output.
- `xor_out`  in  1  observed XOR gate output.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `pass`  out  1  valid when done: 1 if err_count == 0.
- `fail_pulse`  out  1  one-cycle pulse per mismatching vector.
- `vec_count`  out  CNT_W  vectors accepted this run.
- `err_count`  out  CNT_W  mismatching vectors this run; saturates at all-ones.
- `first_fail_valid`  out  1  a mismatch has been recorded this run.
- `first_fail_idx`  out  CNT_W  vec_count value (0-based) of the first mismatch.

## Operation
States: IDLE, RUN, DONE.
- **IDLE**
  - `start` → RUN; all counters and flags are cleared.
  - `in_valid` is ignored.
- **RUN**
  - Accepting a vector: each cycle with `in_valid` high samples all four data inputs.
  - Expected values: `exp_and = in_a & in_b`, `exp_xor = in_a ^ in_b`.
  - A mismatch is any inequality on either output; one vector with both outputs wrong counts as one error.
  - On mismatch:
    - `err_count` increments, holding at all-ones once there.
    - `fail_pulse` is asserted.
    - If `first_fail_valid` is 0: capture the current `vec_count` into `first_fail_idx` and set `first_fail_valid`.
  - `vec_count` increments on every accepted vector.
  - The vector that makes `vec_count` reach `NUM_VECTORS` moves the FSM to DONE.
- **DONE**
  - All results hold and `in_valid` is ignored.
  - `start` clears results and re-enters RUN.
- **`start` during RUN:** aborts the run, clears everything and stays in RUN. A vector on the same cycle is discarded.
- **`start` and `in_valid` together in IDLE or DONE:** `start` wins and the vector is not counted.
- **Reset mid-run:** all outputs go to their reset values immediately (asynchronous). No partial results survive.

## Timing
- **Reset values:** state IDLE; `busy` 0, `done` 0, `pass` 0, `fail_pulse` 0, `vec_count` 0, `err_count` 0, `first_fail_valid` 0, `first_fail_idx` 0.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **`start` latency:** `start` sampled at edge N gives `busy` = 1 after edge N. The first vector can be accepted at edge N+1.
- **Vector update latency:** a vector sampled at edge N updates `vec_count`, `err_count` and `fail_pulse` after edge N. `fail_pulse` drops after edge N+1 unless the next vector also fails.
- **Run completion:** when the last vector is sampled at edge N, `done` and `pass` are valid after edge N and `busy` falls at the same time.
- **Throughput:** one vector per cycle, with no backpressure.

## Structure
- **Shared package `gate_check_pkg`:**
  - `state_t` enum (IDLE, RUN, DONE).
  - Function `gate_expect(a, b)` returning `{and, xor}`.
- **Sub-module `gate_ref_model`:** combinational golden model for the two gates (inputs a, b; outputs exp_and, exp_xor). It is reused later by other gate benches.
- **Top level:** the FSM, counters and first-fail capture live in the top module.

## Test plan
- **All pass, default parameters:** `start`, then vectors (0,0), (0,1), (1,1), (1,0), each with correct outputs.
  - Required: `done` = 1 and `pass` = 1 one cycle after the fourth vector.
  - Required: `err_count` = 0, `vec_count` = 4, `first_fail_valid` = 0.
- **Single fault:** the third vector (1,1) is driven with `and_out` = 0.
  - Required: `fail_pulse` for exactly one cycle.
  - Required: `first_fail_idx` = 2, `err_count` = 1, and finally `pass` = 0.
- **Double-wrong vector plus later fault:**
  - Vector 0 (0,1) arrives with `and_out` = 1 and `xor_out` = 0.
  - Vector 3 (1,0) arrives with `xor_out` = 0.
  - Required: `err_count` = 2, `first_fail_idx` = 0.
- **Gaps and ignored strobes:**
  - `in_valid` is low for 3 cycles between vectors: no count changes during the gaps.
  - `in_valid` pulses while in IDLE and in DONE: no count changes.
- **Restart and simultaneous start:**
  - `start` during RUN after 2 vectors, together with a valid vector: `vec_count` = 0 on the next cycle and the vector is dropped.
  - 4 further good vectors then give `pass` = 1.
- **Reset mid-run:** `rst_n` asserted low between clock edges after 1 failing vector. All outputs must be 0 immediately, without waiting for a clock edge.
